noc_beat_serializer: RTL and testbench

- Downstream neighbour of the method-to-pipe indication stage: consumes one wide NOC message per transfer (16-bit length plus 128-bit data, NOCDataH layout) and emits it as a stream of 32-bit beats onto a narrow PipeIn link.
- Each message goes out as one header beat followed by 0..4 data beats.
- Sits between the M2P indication pipe and the narrow host/NOC transport.

---
 rtl/noc_beat_serializer_pkg.sv | 21 ++
 rtl/noc_beat_serializer.sv | 120 ++++++++++++
 tb/tb_noc_beat_serializer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/noc_beat_serializer_pkg.sv
// Shared types and constants for the NOC wide-to-narrow beat serializer.
// NOCDataH packs data above the 16-bit length field.
package noc_beat_serializer_pkg;

  localparam int NOC_LEN_WIDTH  = 16;
  localparam int NOC_DATA_WIDTH = 128;
  localparam int NOC_BEAT_WIDTH = 32;
  localparam int NOC_MAX_BEATS  = NOC_DATA_WIDTH / NOC_BEAT_WIDTH;

  typedef struct packed {
    logic [NOC_DATA_WIDTH-1:0] data;
    logic [NOC_LEN_WIDTH-1:0]  length;
  } noc_data_h_t;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } ser_state_e;

endpackage

// File: rtl/noc_beat_serializer.sv
// Serializes one wide NOCDataH message into a header beat plus up to
// DATA_WIDTH/BEAT_WIDTH data beats, LSB word first.
module noc_beat_serializer
  import noc_beat_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int LEN_WIDTH  = NOC_LEN_WIDTH,
  parameter int BEAT_WIDTH = NOC_BEAT_WIDTH
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           in_enq__ENA,
  input  logic [LEN_WIDTH+DATA_WIDTH-1:0] in_enq_v,
  output logic                           in_enq__RDY,
  output logic                           out_enq__ENA,
  output logic [BEAT_WIDTH-1:0]          out_enq_v,
  input  logic                           out_enq__RDY,
  output logic                           len_err
);

  localparam int MAX_BEATS = DATA_WIDTH / BEAT_WIDTH;
  localparam int NB_W      = $clog2(MAX_BEATS + 1);
  localparam int IDX_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  ser_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NB_W-1:0]       nbeats_q, nbeats_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  len_err_q, len_err_d;

  logic [LEN_WIDTH-1:0]  in_len;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  over;
  logic                  accept;
  logic                  last_beat;
  logic [MAX_BEATS-1:0][BEAT_WIDTH-1:0] words;

  assign in_len  = in_enq_v[LEN_WIDTH-1:0];
  assign in_data = in_enq_v[LEN_WIDTH+DATA_WIDTH-1:LEN_WIDTH];
  assign over    = in_len > LEN_WIDTH'(MAX_BEATS);
  assign words   = data_q;
  assign accept  = in_enq__ENA && in_enq__RDY;
  assign len_err = len_err_q;

  // Header is the last beat only for an empty message.
  assign last_beat =
    ((state_q == HDR) && (nbeats_q == '0)) ||
    ((state_q == DATA) &&
     (NB_W'(idx_q) == nbeats_q - NB_W'(1)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      nbeats_q  <= '0;
      len_q     <= '0;
      data_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      nbeats_q  <= nbeats_d;
      len_q     <= len_d;
      data_q    <= data_d;
      len_err_q <= len_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nbeats_d  = nbeats_q;
    len_d     = len_q;
    data_d    = data_q;
    len_err_d = len_err_q;
    if (accept) begin
      len_d     = in_len;
      data_d    = in_data;
      nbeats_d  = over ? NB_W'(MAX_BEATS)
                       : in_len[NB_W-1:0];
      len_err_d = len_err_q | over;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = HDR;
      end
      HDR: begin
        if (out_enq__RDY) begin
          if (nbeats_q != '0) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = accept ? HDR : IDLE;
          end
        end
      end
      DATA: begin
        if (out_enq__RDY) begin
          if (last_beat) state_d = accept ? HDR : IDLE;
          else           idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_enq__RDY  = (state_q == IDLE) ||
                   (last_beat && out_enq__RDY);
    out_enq__ENA = (state_q != IDLE) && out_enq__RDY;
    out_enq_v    = '0;
    unique case (state_q)
      HDR:     out_enq_v = BEAT_WIDTH'(len_q);
      DATA:    out_enq_v = words[idx_q];
      default: out_enq_v = '0;
    endcase
  end

endmodule

// File: tb/tb_noc_beat_serializer.sv
// Directed table-driven bench for noc_beat_serializer.
// Each table row is one clock cycle of stimulus plus expected outputs.
module tb_noc_beat_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_ena;
  logic [143:0] in_v;
  logic         in_rdy;
  logic         out_ena;
  logic [31:0]  out_v;
  logic         out_rdy;
  logic         len_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  noc_beat_serializer dut (
    .CLK          (clk),
    .RST          (rst),
    .in_enq__ENA  (in_ena),
    .in_enq_v     (in_v),
    .in_enq__RDY  (in_rdy),
    .out_enq__ENA (out_ena),
    .out_enq_v    (out_v),
    .out_enq__RDY (out_rdy),
    .len_err      (len_err)
  );

  typedef struct {
    logic         rst;
    logic         ien;
    logic [15:0]  len;
    logic [127:0] data;
    logic         ordy;
    logic         chk;
    logic         eoen;
    logic         cv;
    logic [31:0]  eov;
    logic         eirdy;
    logic         elerr;
  } vec_t;

  vec_t tv[$];

  localparam logic [127:0] D  =
    128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] DA =
    128'hDEADBEEF_DEADBEEF_DEADBEEF_000000A1;
  localparam logic [127:0] DB =
    128'hDEADBEEF_DEADBEEF_DEADBEEF_000000B2;
  localparam logic [127:0] DC =
    128'hDEADBEEF_DEADBEEF_DEADBEEF_000000C3;

  function automatic vec_t mk(
    input logic         r,
    input logic         ien,
    input logic [15:0]  len,
    input logic [127:0] data,
    input logic         ordy,
    input logic         chk,
    input logic         eoen,
    input logic         cv,
    input logic [31:0]  eov,
    input logic         eirdy,
    input logic         elerr
  );
    vec_t t;
    t.rst = r;    t.ien = ien;   t.len = len;
    t.data = data; t.ordy = ordy; t.chk = chk;
    t.eoen = eoen; t.cv = cv;     t.eov = eov;
    t.eirdy = eirdy; t.elerr = elerr;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ien,
                       input logic [15:0] len,
                       input logic [127:0] data,
                       input logic ordy);
    rst     = r;
    in_ena  = ien;
    in_v    = {data, len};
    out_rdy = ordy;
  endtask

  logic [31:0] exp_b [4];
  int got;

  initial begin
    drive(1'b1, 1'b0, 16'd0, '0, 1'b0);

    // rst ien len data ordy | chk eoen cv eov eirdy elerr
    // reset, then length 4 at full rate
    tv.push_back(mk(1,0,0,D,1, 0,0,0,32'h0,1,0));
    tv.push_back(mk(0,1,4,D,1, 1,0,0,32'h0,1,0));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h4,0,0));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h11111111,0,0));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h22222222,0,0));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h33333333,0,0));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h44444444,1,0));
    // length 0, next message taken on its header beat
    tv.push_back(mk(0,1,0,D,1, 1,0,0,32'h0,1,0));
    tv.push_back(mk(0,1,2,D,1, 1,1,1,32'h0,1,0));
    // length 2 with ready pattern 1,0,0,1,1
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h2,0,0));
    tv.push_back(mk(0,0,0,D,0, 1,0,1,32'h11111111,0,0));
    tv.push_back(mk(0,0,0,D,0, 1,0,1,32'h11111111,0,0));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h11111111,0,0));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h22222222,1,0));
    // length 7 clamps to 4 data beats, len_err sticks
    tv.push_back(mk(0,1,7,D,1, 1,0,0,32'h0,1,0));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h7,0,1));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h11111111,0,1));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h22222222,0,1));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h33333333,0,1));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h44444444,1,1));
    // three back-to-back length 1 messages
    tv.push_back(mk(0,1,1,DA,1, 1,0,0,32'h0,1,1));
    tv.push_back(mk(0,0,0,D,1,  1,1,1,32'h1,0,1));
    tv.push_back(mk(0,1,1,DB,1, 1,1,1,32'hA1,1,1));
    tv.push_back(mk(0,0,0,D,1,  1,1,1,32'h1,0,1));
    tv.push_back(mk(0,1,1,DC,1, 1,1,1,32'hB2,1,1));
    tv.push_back(mk(0,0,0,D,1,  1,1,1,32'h1,0,1));
    tv.push_back(mk(0,0,0,D,1,  1,1,1,32'hC3,1,1));
    // reset after header + 1 data beat of a length 4
    tv.push_back(mk(0,1,4,D,1, 1,0,0,32'h0,1,1));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h4,0,1));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h11111111,0,1));
    tv.push_back(mk(1,0,0,D,1, 0,0,0,32'h0,0,0));
    tv.push_back(mk(0,0,0,D,1, 1,0,0,32'h0,1,0));
    tv.push_back(mk(0,1,2,D,1, 1,0,0,32'h0,1,0));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h2,0,0));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h11111111,0,0));
    tv.push_back(mk(0,0,0,D,1, 1,1,1,32'h22222222,1,0));
    tv.push_back(mk(0,0,0,D,1, 1,0,0,32'h0,1,0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].ien, tv[i].len,
            tv[i].data, tv[i].ordy);
      #1;
      if (tv[i].chk) begin
        chk("out_ena", i, 32'(out_ena), 32'(tv[i].eoen));
        chk("in_rdy",  i, 32'(in_rdy),  32'(tv[i].eirdy));
        chk("len_err", i, 32'(len_err), 32'(tv[i].elerr));
        if (tv[i].cv)
          chk("out_v", i, out_v, tv[i].eov);
      end
    end

    // empty message whose header stalls: not yet last-beat ready
    @(negedge clk);
    drive(1'b0, 1'b1, 16'd0, D, 1'b0);
    #1 chk("z_in_rdy", 0, 32'(in_rdy), 32'd1);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 16'd0, D, 1'b0);
      #1;
      chk("z_stall_ena", s, 32'(out_ena), 32'd0);
      chk("z_stall_v",   s, out_v, 32'h0);
      chk("z_stall_rdy", s, 32'(in_rdy), 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd0, D, 1'b1);
    #1;
    chk("z_go_ena", 0, 32'(out_ena), 32'd1);
    chk("z_go_rdy", 0, 32'(in_rdy), 32'd1);
    @(negedge clk);
    #1 chk("z_idle_ena", 0, 32'(out_ena), 32'd0);

    // length 3 under pseudo-random backpressure, bounded wait
    exp_b[0] = 32'h3;
    exp_b[1] = 32'h11111111;
    exp_b[2] = 32'h22222222;
    exp_b[3] = 32'h33333333;
    @(negedge clk);
    drive(1'b0, 1'b1, 16'd3, D, 1'b0);
    #1 chk("r_in_rdy", 0, 32'(in_rdy), 32'd1);
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 16'd0, D,
            1'($urandom_range(0, 1)));
      #1;
      chk("r_ena", c, 32'(out_ena), 32'(out_rdy));
      if (out_ena) begin
        chk("r_beat", got, out_v, exp_b[got]);
        got++;
      end
    end
    chk("r_count", 0, got, 4);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd0, D, 1'b1);
    #1 chk("r_done", 0, 32'(out_ena), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
